alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 16-bit ALU: arbitrates, issues one operation
// at a time and returns the result through a valid/ready response port.
module alu_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_imm,
    input  logic [15:0] req0_imm_val,
    input  logic [3:0]  req0_func,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_imm,
    input  logic [15:0] req1_imm_val,
    input  logic [3:0]  req1_func,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [15:0] alu_imm_val,
    output logic        alu_imm,
    output logic [3:0]  alu_func,
    input  logic [15:0] alu_out,
    input  logic [7:0]  alu_status,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic [7:0]  rsp_status,
    output logic        busy,
    output logic [15:0] ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   last_grant;
    logic   grant0;
    logic   grant1;

    // Grant is combinational so the requester sees ready in the same cycle it is captured.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (req0_valid && req1_valid) begin
                if (FIXED_PRIO != 0 || last_grant)
                    grant0 = 1'b1;
                else
                    grant1 = 1'b1;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_imm_val <= '0;
            alu_imm     <= 1'b0;
            alu_func    <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            rsp_status  <= '0;
            busy        <= 1'b0;
            ops_done    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        if (grant1) begin
                            alu_a       <= req1_a;
                            alu_b       <= req1_b;
                            alu_imm     <= req1_imm;
                            alu_imm_val <= req1_imm_val;
                            alu_func    <= req1_func;
                        end else begin
                            alu_a       <= req0_a;
                            alu_b       <= req0_b;
                            alu_imm     <= req0_imm;
                            alu_imm_val <= req0_imm_val;
                            alu_func    <= req0_func;
                        end
                        rsp_id     <= grant1;
                        last_grant <= grant1;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data   <= alu_out;
                    rsp_status <= alu_status;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        ops_done  <= ops_done + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share stimulus and
// are each compared every cycle against a transaction-level model, plus literal spot checks.
module tb_alu_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                rsp_ready;
    logic [1:0]          vld;
    logic [1:0][15:0]    a, b, iv;
    logic [1:0]          imm;
    logic [1:0][3:0]     fn;

    logic [1:0]          rdy0, rdy1, o_imm, rv, rid, bsy;
    logic [1:0][15:0]    oa, ob, oiv, rdata, od, alu_o;
    logic [1:0][3:0]     of;
    logic [1:0][7:0]     rstat, alu_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pend;
        int unsigned age;
        logic        id;
        logic [15:0] a, b, iv;
        logic        imm;
        logic [3:0]  f;
        logic [15:0] data;
        logic [7:0]  st;
        logic        last;
        logic [15:0] cnt;
    } mdl_t;
    mdl_t m[2];

    function automatic logic [15:0] alu_res(input logic [15:0] x, input logic [15:0] y, input logic [3:0] f);
        case (f)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x ^ y;
            4'd3: return x & y;
            4'd4: return x | y;
            4'd5: return x << y[3:0];
            4'd6: return x >> y[3:0];
            default: return ~x;
        endcase
    endfunction

    function automatic logic [7:0] alu_st(input logic [15:0] x, input logic [15:0] y, input logic [3:0] f,
                                          input logic [15:0] r);
        return {f, r == 16'd0, r[15], x[15] ^ y[15], ^r};
    endfunction

    // The environment's ALU, one per instance, driven from each DUT's alu_* registers.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            alu_o[k] = alu_res(oa[k], o_imm[k] ? oiv[k] : ob[k], of[k]);
            alu_s[k] = alu_st(oa[k], o_imm[k] ? oiv[k] : ob[k], of[k], alu_o[k]);
        end
    end

    alu_arbiter #(.FIXED_PRIO(0)) dut0 (
        .clk(clk), .rst(rst),
        .req0_valid(vld[0]), .req0_ready(rdy0[0]), .req0_a(a[0]), .req0_b(b[0]),
        .req0_imm(imm[0]), .req0_imm_val(iv[0]), .req0_func(fn[0]),
        .req1_valid(vld[1]), .req1_ready(rdy1[0]), .req1_a(a[1]), .req1_b(b[1]),
        .req1_imm(imm[1]), .req1_imm_val(iv[1]), .req1_func(fn[1]),
        .alu_a(oa[0]), .alu_b(ob[0]), .alu_imm_val(oiv[0]), .alu_imm(o_imm[0]), .alu_func(of[0]),
        .alu_out(alu_o[0]), .alu_status(alu_s[0]),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]), .rsp_data(rdata[0]),
        .rsp_status(rstat[0]), .busy(bsy[0]), .ops_done(od[0])
    );

    alu_arbiter #(.FIXED_PRIO(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(vld[0]), .req0_ready(rdy0[1]), .req0_a(a[0]), .req0_b(b[0]),
        .req0_imm(imm[0]), .req0_imm_val(iv[0]), .req0_func(fn[0]),
        .req1_valid(vld[1]), .req1_ready(rdy1[1]), .req1_a(a[1]), .req1_b(b[1]),
        .req1_imm(imm[1]), .req1_imm_val(iv[1]), .req1_func(fn[1]),
        .alu_a(oa[1]), .alu_b(ob[1]), .alu_imm_val(oiv[1]), .alu_imm(o_imm[1]), .alu_func(of[1]),
        .alu_out(alu_o[1]), .alu_status(alu_s[1]),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]), .rsp_data(rdata[1]),
        .rsp_status(rstat[1]), .busy(bsy[1]), .ops_done(od[1])
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_model(input int k);
        m[k].pend = 1'b0; m[k].age = 0; m[k].id = 1'b0;
        m[k].a = '0; m[k].b = '0; m[k].iv = '0; m[k].imm = 1'b0; m[k].f = '0;
        m[k].data = '0; m[k].st = '0; m[k].last = 1'b1; m[k].cnt = '0;
    endtask

    // Who may be granted right now: nobody while busy or in reset; a tie goes to req0 under
    // fixed priority (instance 1), otherwise to whichever requester was not granted last.
    function automatic logic [1:0] exp_grant(input int k);
        if (rst || m[k].pend) return 2'b00;
        if (vld == 2'b11) return (k == 1 || m[k].last) ? 2'b01 : 2'b10;
        return vld;
    endfunction

    always @(negedge clk) begin : cmp
        logic [1:0]  g;
        logic [15:0] eb;
        int          idx;
        for (int k = 0; k < 2; k++) begin
            g = exp_grant(k);
            chk($sformatf("dut%0d req0_ready", k), 16'(rdy0[k]), 16'(g[0]));
            chk($sformatf("dut%0d req1_ready", k), 16'(rdy1[k]), 16'(g[1]));
            chk($sformatf("dut%0d busy", k), 16'(bsy[k]), 16'(m[k].pend));
            chk($sformatf("dut%0d rsp_valid", k), 16'(rv[k]), 16'(m[k].pend && m[k].age >= 2));
            chk($sformatf("dut%0d rsp_id", k), 16'(rid[k]), 16'(m[k].id));
            chk($sformatf("dut%0d rsp_data", k), rdata[k], m[k].data);
            chk($sformatf("dut%0d rsp_status", k), 16'(rstat[k]), 16'(m[k].st));
            chk($sformatf("dut%0d alu_a", k), oa[k], m[k].a);
            chk($sformatf("dut%0d alu_b", k), ob[k], m[k].b);
            chk($sformatf("dut%0d alu_imm", k), 16'(o_imm[k]), 16'(m[k].imm));
            chk($sformatf("dut%0d alu_imm_val", k), oiv[k], m[k].iv);
            chk($sformatf("dut%0d alu_func", k), 16'(of[k]), 16'(m[k].f));
            chk($sformatf("dut%0d ops_done", k), od[k], m[k].cnt);
            if (rst) begin
                reset_model(k);
            end else if (m[k].pend) begin
                if (m[k].age == 1) begin
                    m[k].age = 2;
                    eb = m[k].imm ? m[k].iv : m[k].b;
                    m[k].data = alu_res(m[k].a, eb, m[k].f);
                    m[k].st = alu_st(m[k].a, eb, m[k].f, m[k].data);
                end else if (rsp_ready) begin
                    m[k].pend = 1'b0;
                    m[k].cnt = m[k].cnt + 16'd1;
                end
            end else if (g != 2'b00) begin
                idx = g[1] ? 1 : 0;
                m[k].pend = 1'b1; m[k].age = 1; m[k].id = g[1]; m[k].last = g[1];
                m[k].a = a[idx]; m[k].b = b[idx]; m[k].iv = iv[idx];
                m[k].imm = imm[idx]; m[k].f = fn[idx];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int order[$];
    int when[$];
    int fp_acc;

    initial begin
        reset_model(0);
        reset_model(1);
        rst = 1'b1; rsp_ready = 1'b1; vld = 2'b00;
        a = '0; b = '0; iv = '0; imm = '0; fn = '0;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset rsp_valid", 16'(rv[0]), 16'd0);
        chk("reset busy", 16'(bsy[0]), 16'd0);
        chk("reset ops_done", od[0], 16'd0);
        chk("reset alu_a", oa[0], 16'd0);

        // Single op: 4 ^ 3 = 7, status {func=2, zero=0, neg=0, sign-diff=0, parity=1}.
        cyc();
        vld = 2'b01; a[0] = 16'd4; b[0] = 16'd3; fn[0] = 4'b0010; imm[0] = 1'b0;
        @(negedge clk);
        chk("single req0_ready", 16'(rdy0[0]), 16'd1);
        cyc(); vld = 2'b00;
        @(negedge clk);
        chk("exec alu_a", oa[0], 16'd4);
        chk("exec alu_b", ob[0], 16'd3);
        chk("exec alu_func", 16'(of[0]), 16'd2);
        chk("exec rsp_valid", 16'(rv[0]), 16'd0);
        cyc();
        @(negedge clk);
        chk("T+2 rsp_valid", 16'(rv[0]), 16'd1);
        chk("T+2 rsp_id", 16'(rid[0]), 16'd0);
        chk("T+2 rsp_data", rdata[0], 16'h0007);
        chk("T+2 rsp_status", 16'(rstat[0]), 16'h0021);
        cyc();
        @(negedge clk);
        chk("single ops_done", od[0], 16'd1);

        // Tie after reset, both requesters valid continuously.
        cyc(); rst = 1'b1;
        cyc();
        rst = 1'b0; vld = 2'b11; fp_acc = 0;
        a[0] = 16'($urandom); b[0] = 16'($urandom); a[1] = 16'($urandom); b[1] = 16'($urandom);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (rdy0[0]) begin order.push_back(0); when.push_back(i); end
            if (rdy1[0]) begin order.push_back(1); when.push_back(i); end
            chk("fixed req1_ready", 16'(rdy1[1]), 16'd0);
            if (rdy0[1]) fp_acc++;
            cyc();
        end
        vld = 2'b00;
        chk("rr grant count", 16'(order.size()), 16'd5);
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) begin
                chk($sformatf("rr grant %0d id", i), 16'(order[i]), 16'(i % 2));
                chk($sformatf("rr grant %0d cycle", i), 16'(when[i]), 16'(3 * i));
            end
        end
        chk("fixed accepts", 16'(fp_acc), 16'd5);
        repeat (4) cyc();

        // Backpressure on req0's response while req1 waits with an immediate operand.
        vld = 2'b01; a[0] = 16'($urandom); rsp_ready = 1'b0;
        a[1] = 16'h0055; b[1] = 16'($urandom); imm[1] = 1'b1; iv[1] = 16'h1200; fn[1] = 4'd0;
        @(negedge clk);
        chk("bp accept", 16'(rdy0[0]), 16'd1);
        cyc(); vld = 2'b10;
        @(negedge clk);
        chk("bp exec busy", 16'(bsy[0]), 16'd1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp rsp_valid", 16'(rv[0]), 16'd1);
            chk("bp busy", 16'(bsy[0]), 16'd1);
            chk("bp req1_ready", 16'(rdy1[0]), 16'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release rsp_valid", 16'(rv[0]), 16'd1);
        cyc();
        @(negedge clk);
        chk("bp idle busy", 16'(bsy[0]), 16'd0);
        chk("imm req1_ready", 16'(rdy1[0]), 16'd1);
        cyc(); vld = 2'b00;
        @(negedge clk);
        chk("imm alu_imm", 16'(o_imm[0]), 16'd1);
        chk("imm alu_imm_val", oiv[0], 16'h1200);
        cyc();
        @(negedge clk);
        chk("imm rsp_id", 16'(rid[0]), 16'd1);
        chk("imm rsp_data", rdata[0], 16'h1255);
        repeat (3) cyc();

        // Reset landing in EXEC drops the operation.
        vld = 2'b01; imm[1] = 1'b0;
        @(negedge clk);
        chk("mid accept", 16'(rdy0[0]), 16'd1);
        cyc(); vld = 2'b00; rst = 1'b1;
        @(negedge clk);
        chk("mid exec busy", 16'(bsy[0]), 16'd1);
        cyc(); vld = 2'b11;
        @(negedge clk);
        chk("rst req0_ready", 16'(rdy0[0]), 16'd0);
        chk("rst req1_ready", 16'(rdy1[0]), 16'd0);
        cyc(); rst = 1'b0; vld = 2'b00;
        @(negedge clk);
        chk("mid rsp_valid", 16'(rv[0]), 16'd0);
        chk("mid busy", 16'(bsy[0]), 16'd0);
        chk("mid ops_done", od[0], 16'd0);
        chk("mid alu_a", oa[0], 16'd0);
        chk("mid alu_func", 16'(of[0]), 16'd0);

        // Counter wrap from a preloaded all-ones value.
        cyc();
        force dut0.ops_done = 16'hFFFF;
        force dut1.ops_done = 16'hFFFF;
        m[0].cnt = 16'hFFFF;
        m[1].cnt = 16'hFFFF;
        #1;
        release dut0.ops_done;
        release dut1.ops_done;
        vld = 2'b01;
        @(negedge clk);
        chk("preload ops_done", od[0], 16'hFFFF);
        cyc(); vld = 2'b00;
        cyc(); cyc();
        @(negedge clk);
        chk("wrap ops_done", od[0], 16'h0000);

        // Random traffic, backpressure and occasional reset; the compare process checks all.
        for (int i = 0; i < 800; i++) begin
            cyc();
            vld = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                a[k] = 16'($urandom); b[k] = 16'($urandom); iv[k] = 16'($urandom);
                imm[k] = 1'($urandom); fn[k] = 4'($urandom);
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 99) == 0);
        end
        cyc(); rst = 1'b0; vld = 2'b00;
        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
